// File: rtl/led_pwm_scheduler.sv
// led_pwm_scheduler
//   Keeps a user-requested brightness (target) that is nudged up or down by
//   debounced button events, slews the displayed brightness (level) toward it
//   one step per ramp tick, and drives a 255-step PWM from level.
//
// Ports
//   clk_25mhz   in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   up_pulse    in   one-cycle "brighter" event
//   down_pulse  in   one-cycle "dimmer" event
//   pwm_o       out  registered PWM drive
//   level       out  current (ramping) brightness
//   target      out  requested brightness
//   busy        out  high while ramping in either direction
module led_pwm_scheduler #(
    parameter int STEP     = 16,
    parameter int RAMP_DIV = 250000,
    parameter int PRESCALE = 1
) (
    input  logic       clk_25mhz,
    input  logic       rst_n,
    input  logic       up_pulse,
    input  logic       down_pulse,
    output logic       pwm_o,
    output logic [7:0] level,
    output logic [7:0] target,
    output logic       busy
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [7:0]    level_next;
    logic [7:0]    target_next;
    logic [RW-1:0] ramp_cnt;
    logic [PW-1:0] pre_cnt;
    logic          ramp_tick;
    logic          pwm_tick;
    logic [7:0]    pwm_cnt;
    logic [7:0]    compare;
    logic [8:0]    up_sum;

    // Both dividers free-run from reset; a tick is the last count of each
    // period, so the first tick lands exactly DIV cycles after release.
    assign ramp_tick = (ramp_cnt == RW'(RAMP_DIV - 1));
    assign pwm_tick  = (pre_cnt == PW'(PRESCALE - 1));

    // NOTE: every register, including the PWM compare and counter, is cleared
    // by the asynchronous reset so a mid-ramp reset leaves nothing to resume.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            ramp_cnt <= '0;
            pre_cnt  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + RW'(1);
            pre_cnt  <= pwm_tick  ? '0 : pre_cnt + PW'(1);
        end
    end

    // Saturating target arithmetic; simultaneous up/down cancel.
    assign up_sum = {1'b0, target} + 9'(STEP);

    always_comb begin
        // NOTE: default first so no path through the block infers a latch.
        target_next = target;
        if (up_pulse && !down_pulse) begin
            target_next = (up_sum > 9'd255) ? 8'hFF : up_sum[7:0];
        end else if (down_pulse && !up_pulse) begin
            target_next = (target < 8'(STEP)) ? 8'h00 : target - 8'(STEP);
        end
    end

    // Ramp FSM. A ramp state only steps in its own direction; if target has
    // crossed level it first switches state, so no step goes the wrong way.
    always_comb begin
        state_next = state;
        level_next = level;
        unique case (state)
            IDLE: begin
                if (target > level)      state_next = RAMP_UP;
                else if (target < level) state_next = RAMP_DN;
            end
            RAMP_UP: begin
                if (level == target)     state_next = IDLE;
                else if (target < level) state_next = RAMP_DN;
                else if (ramp_tick)      level_next = level + 8'd1;
            end
            RAMP_DN: begin
                if (level == target)     state_next = IDLE;
                else if (target > level) state_next = RAMP_UP;
                else if (ramp_tick)      level_next = level - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            level  <= 8'd0;
            target <= 8'd0;
        end else begin
            state  <= state_next;
            level  <= level_next;
            target <= target_next;
        end
    end

    assign busy = (state != IDLE);

    // PWM: counter spans 0..254 (255 steps) so compare 255 means always on.
    // compare is reloaded only at the wrap, keeping duty fixed per period.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'd0;
            compare <= 8'd0;
            pwm_o   <= 1'b0;
        end else begin
            pwm_o <= (pwm_cnt < compare);
            if (pwm_tick) begin
                if (pwm_cnt == 8'd254) begin
                    pwm_cnt <= 8'd0;
                    compare <= level;
                end else begin
                    pwm_cnt <= pwm_cnt + 8'd1;
                end
            end
        end
    end

endmodule
